z80_incdec_sequencer: RTL and testbench
=======================================

// Module: z80_incdec_sequencer
// PURPOSE
//  Sequences the Z80 core's single shared 16-bit +/-1 unit over the register file.
//  Executes INC/DEC dd (one op) and the pointer/counter updates of block instructions
//  LDI/LDD/CPI/CPD: HL+/-1, DE+/-1 (LD* only), then BC-1.
//  Sits between the decoder (command side) and the register-file read/write ports.
//  Updates no flags except bc_zero, the P/V source for block instructions.
// PARAMETERS
//  DATA_W   16  register-pair width; only 16 is supported
//  SEL_W    2   register-pair selector width; encoding is `REG_BC/`REG_DE/`REG_HL/`REG_SP from z80.vh
// PORTS
//  clk         in   1       core clock; all state changes on its rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  cmd_valid   in   1       command offered
//  cmd_ready   out  1       sequencer can accept; high only in IDLE
//  cmd_block   in   1       0 = INC/DEC dd; 1 = block-instruction update
//  cmd_dd      in   SEL_W   target pair for single op; ignored when cmd_block=1
//  cmd_dec     in   1       1 = decrement (single op, or HL/DE direction for block)
//  cmd_use_de  in   1       block only: 1 = also step DE (LDI/LDD), 0 = skip DE (CPI/CPD)
//  abort       in   1       synchronous cancel of the command in flight
//  rd_sel      out  SEL_W   register-file read selector
//  rd_data     in   DATA_W  register-file read data, combinational from rd_sel
//  wr_en       out  1       register-file write strobe
//  wr_sel      out  SEL_W   register-file write selector
//  wr_data     out  DATA_W  register-file write data
//  done        out  1       one-cycle pulse on the last write of a command
//  bc_zero     out  1       registered; 1 when the last BC write by this block was 0x0000
// BEHAVIOUR
//  Reset (async assert): state=IDLE, op index=0, operand reg=0, bc_zero=0.
//   Outputs while reset is held: cmd_ready=1, wr_en=0, done=0, rd_sel=0, wr_sel=0, wr_data=0.
//  States: IDLE -> RD -> WR -> (RD of next op | IDLE).
//  IDLE:
//   - cmd_ready=1.
//   - On cmd_valid & cmd_ready, latch cmd_*, clear op index, go to RD.
//  Op list:
//   - single: [dd, dir=cmd_dec].
//   - block use_de=1: [HL, DE, BC-dec]. block use_de=0: [HL, BC-dec].
//   - HL/DE direction is cmd_dec; BC is always decremented.
//  RD:
//   - rd_sel = current op's pair.
//   - Register rd_data +/-1 into the operand reg; go to WR.
//  WR:
//   - wr_en=1, wr_sel=current pair, wr_data=operand reg.
//   - If last op: done=1 and go to IDLE. Otherwise advance op index and go to RD.
//  Timing:
//   - Accept at edge T. First read in cycle T+1, first write in T+2.
//   - Single op: done in T+2. Block: done in T+6 (use_de=1) or T+4 (use_de=0).
//   - cmd_ready is low from T+1 through the final WR cycle.
//   - Next accept is no earlier than the IDLE cycle after done; no back-to-back overlap.
//  Arithmetic:
//   - Modulo 2^16, no carry out. 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
//   - INC/DEC dd never touches bc_zero, even when dd=`REG_BC.
//   - bc_zero is updated only on the block BC write: bc_zero <= (wr_data==0).
//   - BC 0x0001 -> 0x0000 gives bc_zero=1. BC 0x0000 -> 0xFFFF gives bc_zero=0 (65536-iteration case).
//  abort (priority over everything):
//   - In RD or WR: suppress wr_en and done that cycle; go to IDLE next edge.
//   - Writes already completed for the command stay committed.
//   - In IDLE: no effect, and blocks acceptance that cycle (cmd_ready forced 0).
//  reset_n asserted mid-command: immediate IDLE; no further writes; bc_zero cleared.
//  Outputs when not in WR: wr_en=0, done=0. wr_sel/wr_data hold the last values (don't-care).
// STRUCTURE
//  Package z80_incdec_pkg:
//   - state enum (IDLE, RD, WR).
//   - op-list encoding {pair, dec}.
//   - MAX_OPS=3.
//  Selector constants: reuse `REG_* from z80.vh; no local redefinition.
//  Sub-module z80_incdec16: combinational {a, dec} -> a+/-1 (16-bit).
//   - Exactly one instance in this block.
// TESTING
//  INC BC, BC=0x12FF: accept at T -> rd_sel=BC at T+1; wr_en, wr_data=0x1300, done at T+2; bc_zero unchanged.
//  DEC SP, SP=0x0000 -> wr_sel=SP, wr_data=0xFFFF (wrap); INC HL, HL=0xFFFF -> wr_data=0x0000.
//  LDI: HL=0x4000, DE=0x5000, BC=0x0001 -> writes HL=0x4001 (T+2), DE=0x5001 (T+4), BC=0x0000 (T+6) with done; bc_zero=1.
//  CPD: HL=0x4000, BC=0x0000 -> HL=0x3FFF (T+2), BC=0xFFFF (T+4) with done; DE never selected; bc_zero=0.
//  abort in 2nd RD of LDI -> only the HL write occurs; no done; cmd_ready=1 next cycle; next command behaves normally.
//  reset_n low during a block WR -> wr_en drops asynchronously, cmd_ready=1, bc_zero=0; cmd_valid during reset is ignored.

Source files
------------

// File: rtl/z80_incdec_pkg.sv
// Shared types and op-list helpers for the Z80 16-bit increment/decrement sequencer.
// Register-pair selectors follow the Z80 dd field encoding (normally provided by z80.vh).
`ifndef REG_BC
`define REG_BC 2'b00
`define REG_DE 2'b01
`define REG_HL 2'b10
`define REG_SP 2'b11
`endif

package z80_incdec_pkg;

  localparam int MAX_OPS = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  typedef struct packed {
    logic [1:0] pair;
    logic       dec;
  } op_t;

  // Block updates walk HL, optionally DE, then BC; BC always counts down.
  function automatic op_t op_at(input logic block, input logic use_de,
                                input logic [1:0] dd, input logic dec,
                                input logic [1:0] idx);
    op_t op;
    op.pair = dd;
    op.dec  = dec;
    if (block) begin
      if (idx == 2'd0) begin
        op.pair = `REG_HL;
      end else if (idx == 2'd1 && use_de) begin
        op.pair = `REG_DE;
      end else begin
        op.pair = `REG_BC;
        op.dec  = 1'b1;
      end
    end
    return op;
  endfunction

  function automatic logic [1:0] last_idx(input logic block, input logic use_de);
    if (!block) return 2'd0;
    if (use_de) return 2'(MAX_OPS - 1);
    return 2'd1;
  endfunction

endpackage

// File: rtl/z80_incdec16.sv
// Combinational 16-bit +/-1 unit shared by every register-pair update.
module z80_incdec16 #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic              dec,
  output logic [DATA_W-1:0] y
);

  assign y = dec ? (a - DATA_W'(1)) : (a + DATA_W'(1));

endmodule

// File: rtl/z80_incdec_sequencer.sv
// Steps register pairs through the single shared +/-1 unit: INC/DEC dd and the
// HL/DE/BC pointer and counter updates of LDI/LDD/CPI/CPD.
module z80_incdec_sequencer
  import z80_incdec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_block,
  input  logic [SEL_W-1:0]  cmd_dd,
  input  logic              cmd_dec,
  input  logic              cmd_use_de,
  input  logic              abort,
  output logic [SEL_W-1:0]  rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              bc_zero
);

  logic [1:0]        state_reg, state_next;
  logic [1:0]        op_idx_reg, op_idx_next;
  logic [DATA_W-1:0] operand_reg;
  logic              bc_zero_reg;
  logic              cmd_block_reg;
  logic [SEL_W-1:0]  cmd_dd_reg;
  logic              cmd_dec_reg;
  logic              cmd_use_de_reg;

  op_t               cur_op;
  logic              last_op;
  logic              accept;
  logic [DATA_W-1:0] alu_y;

  assign cur_op  = op_at(cmd_block_reg, cmd_use_de_reg, cmd_dd_reg, cmd_dec_reg, op_idx_reg);
  assign last_op = (op_idx_reg == last_idx(cmd_block_reg, cmd_use_de_reg));

  z80_incdec16 #(.DATA_W(DATA_W)) u_incdec (
    .a   (rd_data),
    .dec (cur_op.dec),
    .y   (alu_y)
  );

  // abort wins over acceptance and over the write strobe in the same cycle.
  assign cmd_ready = (state_reg == ST_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign wr_en     = (state_reg == ST_WR) && !abort;
  assign done      = wr_en && last_op;
  assign rd_sel    = cur_op.pair;
  assign wr_sel    = cur_op.pair;
  assign wr_data   = operand_reg;
  assign bc_zero   = bc_zero_reg;

  always_comb begin
    state_next  = state_reg;
    op_idx_next = op_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next  = ST_RD;
          op_idx_next = 2'd0;
        end
      end
      ST_RD: begin
        state_next = abort ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        if (abort || last_op) begin
          state_next = ST_IDLE;
        end else begin
          state_next  = ST_RD;
          op_idx_next = op_idx_reg + 2'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      op_idx_reg     <= 2'd0;
      operand_reg    <= '0;
      bc_zero_reg    <= 1'b0;
      cmd_block_reg  <= 1'b0;
      cmd_dd_reg     <= '0;
      cmd_dec_reg    <= 1'b0;
      cmd_use_de_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_idx_reg <= op_idx_next;
      if (accept) begin
        cmd_block_reg  <= cmd_block;
        cmd_dd_reg     <= cmd_dd;
        cmd_dec_reg    <= cmd_dec;
        cmd_use_de_reg <= cmd_use_de;
      end
      if (state_reg == ST_RD && !abort) begin
        operand_reg <= alu_y;
      end
      // Only the closing BC write of a block instruction feeds P/V.
      if (wr_en && cmd_block_reg && last_op) begin
        bc_zero_reg <= (operand_reg == '0);
      end
    end
  end

endmodule

// File: tb/tb_z80_incdec_sequencer.sv
// Randomized and directed bench for z80_incdec_sequencer with a register-file model.
module tb_z80_incdec_sequencer;

  localparam logic [1:0] P_BC = 2'd0;
  localparam logic [1:0] P_DE = 2'd1;
  localparam logic [1:0] P_HL = 2'd2;
  localparam logic [1:0] P_SP = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_block;
  logic [1:0]  cmd_dd;
  logic        cmd_dec;
  logic        cmd_use_de;
  logic        abort;
  logic [1:0]  rd_sel;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;
  logic        done;
  logic        bc_zero;

  // Register file around the DUT, plus a preload port used between commands.
  logic [15:0] rf [4];
  logic        poke_en;
  logic [63:0] poke_vals;

  // Expected register contents and bc_zero, advanced from the instruction rules.
  logic [15:0] m_regs [4];
  logic        m_bcz;

  int checks = 0;
  int errors = 0;

  z80_incdec_sequencer #(.DATA_W(16), .SEL_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_block  (cmd_block),
    .cmd_dd     (cmd_dd),
    .cmd_dec    (cmd_dec),
    .cmd_use_de (cmd_use_de),
    .abort      (abort),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .done       (done),
    .bc_zero    (bc_zero)
  );

  always #5 clk = ~clk;

  assign rd_data = rf[rd_sel];

  always @(posedge clk) begin
    if (wr_en) begin
      rf[wr_sel] <= wr_data;
    end else if (poke_en) begin
      for (int r = 0; r < 4; r++) rf[r] <= poke_vals[r*16 +: 16];
    end
  end

  task automatic preload(input logic [15:0] bc, input logic [15:0] de,
                         input logic [15:0] hl, input logic [15:0] sp);
    @(negedge clk);
    poke_vals = {sp, hl, de, bc};
    poke_en   = 1'b1;
    m_regs[0] = bc; m_regs[1] = de; m_regs[2] = hl; m_regs[3] = sp;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // cut_at: cycle index after acceptance where abort (or reset when cut_rst) is applied; 0 = none.
  task automatic run_cmd(input bit blk, input logic [1:0] dd, input bit dec,
                         input bit use_de, input int cut_at, input bit cut_rst);
    logic [1:0]  pairs [3];
    bit          ds [3];
    logic [15:0] vals [3];
    int          n;
    int          i;
    if (!blk) begin
      n = 1; pairs[0] = dd; ds[0] = dec;
    end else begin
      pairs[0] = P_HL; ds[0] = dec;
      if (use_de) begin
        pairs[1] = P_DE; ds[1] = dec; pairs[2] = P_BC; ds[2] = 1'b1; n = 3;
      end else begin
        pairs[1] = P_BC; ds[1] = 1'b1; n = 2;
      end
    end
    for (int j = 0; j < n; j++)
      vals[j] = 16'((int'(m_regs[pairs[j]]) + (ds[j] ? 65535 : 1)) % 65536);

    @(negedge clk);
    cmd_block  = blk;
    cmd_dd     = blk ? 2'($urandom) : dd;
    cmd_dec    = dec;
    cmd_use_de = use_de;
    cmd_valid  = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;

    for (int k = 1; k <= 2 * n; k++) begin
      i = (k - 1) / 2;
      if (k == cut_at && !cut_rst) begin
        abort = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, wr_en, done} !== 3'b000) begin
          errors++;
          $display("FAIL abort_cycle k=%0d: ready/wr_en/done=%b expected 000", k, {cmd_ready, wr_en, done});
        end
        @(negedge clk);
        abort = 1'b0;
        break;
      end
      if (k == cut_at && cut_rst) begin
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        m_bcz     = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, wr_en, done, bc_zero, rd_sel, wr_sel, wr_data} !== {4'b1000, 2'b00, 2'b00, 16'h0000}) begin
          errors++;
          $display("FAIL reset_mid k=%0d: ready=%b wr_en=%b done=%b bc_zero=%b rd_sel=%0d wr_sel=%0d wr_data=%h expected 1 0 0 0 0 0 0000",
                   k, cmd_ready, wr_en, done, bc_zero, rd_sel, wr_sel, wr_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        break;
      end
      #1;
      checks++;
      if (k % 2 == 1) begin
        if ({cmd_ready, wr_en, done, rd_sel} !== {3'b000, pairs[i]}) begin
          errors++;
          $display("FAIL read_cycle k=%0d: ready=%b wr_en=%b done=%b rd_sel=%0d expected 0 0 0 %0d",
                   k, cmd_ready, wr_en, done, rd_sel, pairs[i]);
        end
      end else begin
        if ({cmd_ready, wr_en, done, wr_sel, wr_data} !== {2'b01, (i == n - 1), pairs[i], vals[i]}) begin
          errors++;
          $display("FAIL write_cycle k=%0d: ready=%b wr_en=%b done=%b wr_sel=%0d wr_data=%h expected 0 1 %0d %0d %h",
                   k, cmd_ready, wr_en, done, wr_sel, wr_data, (i == n - 1), pairs[i], vals[i]);
        end
        m_regs[pairs[i]] = vals[i];
        if (blk && i == n - 1) m_bcz = (vals[i] == 16'h0000);
      end
      @(negedge clk);
    end

    #1;
    checks++;
    if ({cmd_ready, wr_en, done} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after: ready/wr_en/done=%b expected 100", {cmd_ready, wr_en, done});
    end
    checks++;
    if (bc_zero !== m_bcz) begin
      errors++;
      $display("FAIL bc_zero: got %b expected %b", bc_zero, m_bcz);
    end
    checks++;
    if ({rf[3], rf[2], rf[1], rf[0]} !== {m_regs[3], m_regs[2], m_regs[1], m_regs[0]}) begin
      errors++;
      $display("FAIL regfile: SP/HL/DE/BC=%h %h %h %h expected %h %h %h %h",
               rf[3], rf[2], rf[1], rf[0], m_regs[3], m_regs[2], m_regs[1], m_regs[0]);
    end
    $display("cmd blk=%0d dd=%0d dec=%0d use_de=%0d cut=%0d rst=%0d -> BC=%h DE=%h HL=%h SP=%h bc_zero=%b",
             blk, dd, dec, use_de, cut_at, cut_rst, rf[0], rf[1], rf[2], rf[3], bc_zero);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cmd_ready, wr_en, done, bc_zero, rd_sel, wr_sel, wr_data} !== {4'b1000, 2'b00, 2'b00, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: ready=%b wr_en=%b done=%b bc_zero=%b rd_sel=%0d wr_sel=%0d wr_data=%h expected 1 0 0 0 0 0 0000",
               cmd_ready, wr_en, done, bc_zero, rd_sel, wr_sel, wr_data);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({cmd_ready, wr_en} !== 2'b10) begin
        errors++;
        $display("FAIL reset_release c=%0d: ready/wr_en=%b expected 10", c, {cmd_ready, wr_en});
      end
    end
    $display("reset released: cmd_ready=%b bc_zero=%b", cmd_ready, bc_zero);
  endtask

  task automatic test_single();
    preload(16'h12FF, 16'h1111, 16'hFFFF, 16'h0000);
    run_cmd(1'b0, P_BC, 1'b0, 1'b0, 0, 1'b0);
    run_cmd(1'b0, P_SP, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(1'b0, P_HL, 1'b0, 1'b0, 0, 1'b0);
    run_cmd(1'b0, P_DE, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_block();
    preload(16'h0001, 16'h5000, 16'h4000, 16'h2222);
    run_cmd(1'b1, 2'd0, 1'b0, 1'b1, 0, 1'b0);
    // INC/DEC dd on BC must leave bc_zero alone in both directions.
    preload(16'hFFFF, 16'h5000, 16'h4000, 16'h2222);
    run_cmd(1'b0, P_BC, 1'b0, 1'b0, 0, 1'b0);
    preload(16'h0000, 16'h7777, 16'h4000, 16'h2222);
    run_cmd(1'b1, 2'd0, 1'b1, 1'b0, 0, 1'b0);
    preload(16'h0001, 16'h7777, 16'h4000, 16'h2222);
    run_cmd(1'b0, P_BC, 1'b1, 1'b0, 0, 1'b0);
    preload(16'h0010, 16'h8000, 16'h0000, 16'h2222);
    run_cmd(1'b1, 2'd0, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_abort();
    preload(16'h0001, 16'h5000, 16'h4000, 16'h3333);
    run_cmd(1'b1, 2'd0, 1'b0, 1'b1, 3, 1'b0);
    run_cmd(1'b0, P_SP, 1'b0, 1'b0, 2, 1'b0);
    run_cmd(1'b1, 2'd0, 1'b0, 1'b0, 0, 1'b0);
    // abort while idle blocks acceptance.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_block = 1'b0; cmd_dd = P_HL; abort = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort_ready: cmd_ready=%b expected 0", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({cmd_ready, wr_en} !== 2'b10) begin
        errors++;
        $display("FAIL idle_abort_noaccept c=%0d: ready/wr_en=%b expected 10", c, {cmd_ready, wr_en});
      end
      @(negedge clk);
    end
    $display("idle abort: command not accepted, HL=%h", rf[2]);
  endtask

  task automatic test_random();
    logic [15:0] v [4];
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 4; r++) begin
        case ($urandom_range(0, 5))
          0: v[r] = 16'h0000;
          1: v[r] = 16'h0001;
          2: v[r] = 16'hFFFF;
          default: v[r] = 16'($urandom);
        endcase
      end
      preload(v[0], v[1], v[2], v[3]);
      run_cmd(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    preload(16'h0001, 16'h5000, 16'h4000, 16'h4444);
    run_cmd(1'b1, 2'd0, 1'b0, 1'b1, 0, 1'b0);
    preload(16'h0001, 16'h5000, 16'h4000, 16'h4444);
    run_cmd(1'b1, 2'd0, 1'b0, 1'b1, 6, 1'b1);
    run_cmd(1'b0, P_DE, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b1;
    cmd_block  = 1'b0;
    cmd_dd     = 2'd0;
    cmd_dec    = 1'b0;
    cmd_use_de = 1'b0;
    abort      = 1'b0;
    poke_en    = 1'b0;
    poke_vals  = '0;
    m_bcz      = 1'b0;
    for (int r = 0; r < 4; r++) m_regs[r] = 16'h0000;

    test_reset();
    test_single();
    test_block();
    test_abort();
    test_random();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
